// File: rtl/data_mem_pipe.sv
// Handshaked single-port data RAM with lane write masks, self-clearing init sweep.
// Optional per-lane even parity is built in when DMEM_PARITY_EN is defined.
module data_mem_pipe #(
    parameter int DATA_W = 4,
    parameter int LANE_W = 4,
    parameter int ADDR_W = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic                       req_write,
    input  logic [ADDR_W-1:0]          req_addr,
    input  logic [DATA_W-1:0]          req_wdata,
    input  logic [DATA_W/LANE_W-1:0]   req_wmask,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [DATA_W-1:0]          rsp_rdata,
    output logic                       init_done,
    output logic                       par_err
);

    localparam int NLANES = DATA_W / LANE_W;
    localparam int DEPTH  = 2 ** ADDR_W;

    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]        state_r;
    logic [ADDR_W-1:0] init_cnt_r;
    logic              init_done_r;
    logic              rsp_valid_r;
    logic [DATA_W-1:0] rsp_rdata_r;
    logic [DATA_W-1:0] mem_r [DEPTH];

    logic              accept_s;
    logic              wr_acc_s;
    logic              rd_acc_s;
    logic [DATA_W-1:0] wr_word_s;

`ifdef DMEM_PARITY_EN
    logic [NLANES-1:0] par_r [DEPTH];
    logic [NLANES-1:0] wr_par_s;
    logic              rd_perr_s;
    logic              par_err_r;

    function automatic logic lane_parity(input logic [LANE_W-1:0] d);
        return ^d;
    endfunction
`endif

    // A stalled response blocks new requests; rsp_ready is the only combinational path.
    assign req_ready = init_done_r && !(rsp_valid_r && !rsp_ready);
    assign accept_s  = req_valid && req_ready;
    assign wr_acc_s  = accept_s && req_write;
    assign rd_acc_s  = accept_s && !req_write;

    assign rsp_valid = rsp_valid_r;
    assign rsp_rdata = rsp_rdata_r;
    assign init_done = init_done_r;

    // Merge masked lanes of the write data into the currently stored word
    always_comb begin
        wr_word_s = mem_r[req_addr];
        for (int i = 0; i < NLANES; i++) begin
            wr_word_s[i*LANE_W +: LANE_W] = req_wmask[i] ? req_wdata[i*LANE_W +: LANE_W]
                                                          : mem_r[req_addr][i*LANE_W +: LANE_W];
        end
    end

    // Init sweep sequencing and RUN entry
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_INIT;
            init_cnt_r  <= {ADDR_W{1'b0}};
            init_done_r <= 1'b0;
        end else begin
            case (state_r)
                ST_INIT: begin
                    init_cnt_r <= init_cnt_r + ADDR_W'(1'b1);
                    if (init_cnt_r == {ADDR_W{1'b1}}) begin
                        state_r     <= ST_RUN;
                        init_done_r <= 1'b1;
                    end
                end
                ST_RUN: begin
                    init_done_r <= 1'b1;
                end
                default: begin
                    state_r     <= ST_INIT;
                    init_cnt_r  <= {ADDR_W{1'b0}};
                    init_done_r <= 1'b0;
                end
            endcase
        end
    end

    // Storage array: zero sweep during INIT, masked writes afterwards
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_r == ST_INIT) begin
                mem_r[init_cnt_r] <= {DATA_W{1'b0}};
            end else if (wr_acc_s) begin
                mem_r[req_addr] <= wr_word_s;
            end
        end
    end

`ifdef DMEM_PARITY_EN
    // Fresh parity for written lanes; untouched lanes keep their stored bit so errors persist
    always_comb begin
        wr_par_s  = par_r[req_addr];
        rd_perr_s = 1'b0;
        for (int i = 0; i < NLANES; i++) begin
            wr_par_s[i] = req_wmask[i] ? lane_parity(req_wdata[i*LANE_W +: LANE_W])
                                       : par_r[req_addr][i];
            rd_perr_s   = rd_perr_s |
                          (lane_parity(mem_r[req_addr][i*LANE_W +: LANE_W]) != par_r[req_addr][i]);
        end
    end

    // Parity storage follows the data array
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_r == ST_INIT) begin
                par_r[init_cnt_r] <= {NLANES{1'b0}};
            end else if (wr_acc_s) begin
                par_r[req_addr] <= wr_par_s;
            end
        end
    end

    assign par_err = par_err_r;
`else
    assign par_err = 1'b0;
`endif

    // Response register: load on read accept, hold while stalled, clear once taken
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid_r <= 1'b0;
            rsp_rdata_r <= {DATA_W{1'b0}};
`ifdef DMEM_PARITY_EN
            par_err_r   <= 1'b0;
`endif
        end else if (rd_acc_s) begin
            rsp_valid_r <= 1'b1;
            rsp_rdata_r <= mem_r[req_addr];
`ifdef DMEM_PARITY_EN
            par_err_r   <= rd_perr_s;
`endif
        end else if (rsp_valid_r && rsp_ready) begin
            rsp_valid_r <= 1'b0;
        end
    end

endmodule

// File: doc/data_mem_pipe.md
# data_mem_pipe

Parametrised, handshaked successor to the 4-bit scratch data memory. Provides a single-port synchronous RAM with per-lane write masking, valid/ready request and response channels, and hardware clear-on-reset. It sits between the core's load/store stage and data storage, and can back-pressure the pipeline.

## Interface
Parameters:
- DATA_W, default 4: word width; must be a multiple of LANE_W.
- LANE_W, default 4: write-mask granularity in bits; NLANES = DATA_W/LANE_W.
- ADDR_W, default 4: address width; DEPTH = 2**ADDR_W words.

Ports:
- clk, in, 1: single clock; all logic on posedge.
- rst, in, 1: reset, synchronous, active-high.
- req_valid, in, 1: request present.
- req_ready, out, 1: request accepted when req_valid && req_ready.
- req_write, in, 1: 1 = write, 0 = read.
- req_addr, in, ADDR_W: word address.
- req_wdata, in, DATA_W: write data.
- req_wmask, in, NLANES: per-lane write enable; bit i covers bits [i*LANE_W +: LANE_W].
- rsp_valid, out, 1: read data valid.
- rsp_ready, in, 1: consumer takes the response when rsp_valid && rsp_ready.
- rsp_rdata, out, DATA_W: read data.
- init_done, out, 1: clear sweep complete.
- par_err, out, 1: parity error flag for the current response.

## Operation
- FSM states:
  - INIT: entered on rst. A counter sweeps addresses 0 to DEPTH-1, writing zero to one word per cycle. req_ready is 0 throughout.
  - RUN: entered after address DEPTH-1 is written. init_done is 1.
- Reset values:
  - Outputs: req_ready=0, rsp_valid=0, rsp_rdata=0, init_done=0, par_err=0.
  - State: INIT, with the counter at 0.
- req_ready = init_done && !(rsp_valid && !rsp_ready). It does not depend on req_write.
- Write, on accept: lanes with a mask bit of 1 take req_wdata; other lanes keep their value.
  - A mask of all zeros is accepted as a no-op.
  - Writes are posted and produce no response.
- Read, on accept: the word is registered into rsp_rdata and rsp_valid is set the next cycle.
- Response hold: while rsp_valid && !rsp_ready, rsp_rdata and par_err stay stable and no new request is accepted.
- Response clear: rsp_valid clears when the response is taken with no new read accepted in the same cycle.
- Back-to-back reads: a response taken in the same cycle a new read is accepted is replaced by the new data. Throughput is one read per cycle.
- Read after write: a read of the same address accepted the cycle after a write returns the new data.
- Address range: every ADDR_W value is valid, so there is no out-of-range case.
- rst asserted in any state or cycle:
  - rsp_valid drops the next cycle and any pending response is discarded.
  - The FSM returns to INIT and memory is re-cleared.

## Timing
- Init duration: rst deasserted at cycle 0 gives init_done=1 and req_ready=1 at cycle DEPTH. That is 16 cycles at defaults.
- Read latency: accepted at edge N, rsp_valid and rsp_rdata valid after edge N+1.
- Write visibility: one cycle after acceptance.
- No combinational path from req_* to rsp_*. Only rsp_ready→req_ready is combinational.

## Configuration
- DMEM_PARITY_EN defined:
  - Each lane stores one extra even-parity bit, computed on write.
  - The INIT sweep writes zero data with parity 0.
  - On read, parity is checked per lane. par_err is 1 together with rsp_valid if any lane mismatches, and is held with the response.
- DMEM_PARITY_EN undefined:
  - No parity storage or check logic.
  - par_err is constant 0. The port remains for a stable interface.

## Test plan
Configuration for all scenarios: DATA_W=8, LANE_W=4, ADDR_W=4.
1. Init: release rst. req_ready stays 0 for 16 cycles, then init_done=1. Reads of addresses 0, 7 and 15 each return 0x00 with rsp_valid one cycle after accept.
2. Masked write: write 0xA5 to addr 3 with mask 2'b11, then write 0x3C to addr 3 with mask 2'b01. A read of addr 3 returns 0xAC. A mask-2'b00 write of 0xFF leaves 0xAC.
3. Back-pressure: hold rsp_ready=0 after reading addr 3. rsp_rdata stays 0xAC and req_ready=0 for 5 cycles. Raise rsp_ready with a read of addr 0 queued: the response is taken and the next response is 0x00 one cycle later.
4. Streaming: with rsp_ready=1, issue reads of addr 0–15 on consecutive cycles after writing addr=data. 16 responses arrive on consecutive cycles in order.
5. Reset mid-operation: assert rst while a response is pending on addr 3 (0xAC). rsp_valid=0 the next cycle, INIT re-runs for 16 cycles, then a read of addr 3 returns 0x00.
6. Parity (DMEM_PARITY_EN): write 0x5A to addr 9, then flip stored data bit 0 hierarchically. A read returns par_err=1 with rsp_valid. A read of a clean address gives par_err=0. With the macro undefined, par_err is always 0.
